// File: rtl/spi_slave_fsm_p.sv
// spi_slave_fsm_p: SPI slave front-end that receives command frames and shifts read data out on MISO.
module spi_slave_fsm_p #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W+2)+1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SS_n,
  input  logic                MOSI,
  output logic                MISO,
  output logic [DATA_W+1:0]   rx_data,
  output logic                rx_valid,
  input  logic [DATA_W-1:0]   tx_data,
  input  logic                tx_valid,
  output logic                busy,
  output logic                frame_err
);
  localparam int FRAME_W = DATA_W + 2;
  typedef enum logic [2:0] {
    IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE
  } state_t;
  state_t state, nxt;
  logic [FRAME_W-1:0] sr;
  logic [DATA_W-1:0]  txr;
  logic [CNT_W-1:0]   cnt;
  logic               rd_addr_seen;
  logic               rx_st, last, tx_load, tx_end;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  always_comb begin
    nxt     = state;
    rx_st   = state inside {WRITE, READ_ADD, READ_DATA};
    last    = rx_st && cnt == CNT_W'(FRAME_W-1);
    tx_load = state == TX_WAIT && tx_valid;
    tx_end  = state == TX_SHIFT && cnt == '0;
    case (state)
      IDLE:      nxt = CHK_CMD;
      CHK_CMD:   nxt = !MOSI ? WRITE : rd_addr_seen ? READ_DATA : READ_ADD;
      WRITE,
      READ_ADD:  nxt = last ? DONE : state;
      READ_DATA: nxt = last ? TX_WAIT : state;
      TX_WAIT:   nxt = tx_load ? TX_SHIFT : state;
      TX_SHIFT:  nxt = tx_end ? DONE : state;
      default:   nxt = state;
    endcase
    // SS_n high always returns to IDLE, overriding any frame completion on the same edge
    if (SS_n) nxt = IDLE;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr           <= '0;
      txr          <= '0;
      cnt          <= '0;
      rd_addr_seen <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      MISO         <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= SS_n && state != IDLE && state != DONE;
      if (SS_n) begin
        MISO <= 1'b0;
        cnt  <= '0;
      end else begin
        if (state == IDLE || state == CHK_CMD) cnt <= '0;
        if (rx_st) begin
          sr  <= {sr[FRAME_W-2:0], MOSI};
          cnt <= cnt + 1'b1;
          if (last) begin
            rx_data  <= {sr[FRAME_W-2:0], MOSI};
            rx_valid <= 1'b1;
            if (state == READ_ADD) rd_addr_seen <= 1'b1;
          end
        end
        if (tx_load) begin
          MISO <= tx_data[DATA_W-1];
          txr  <= tx_data << 1;
          cnt  <= CNT_W'(DATA_W-1);
        end
        if (state == TX_SHIFT) begin
          if (tx_end) begin
            MISO         <= 1'b0;
            rd_addr_seen <= 1'b0;
          end else begin
            MISO <= txr[DATA_W-1];
            txr  <= txr << 1;
            cnt  <= cnt - 1'b1;
          end
        end
      end
    end
endmodule

// File: tb/tb_spi_slave_fsm_p.sv
// tb_spi_slave_fsm_p: directed checks of spi_slave_fsm_p at DATA_W=8 and DATA_W=16.
module tb_spi_slave_fsm_p;
  logic        clk = 1'b0;
  logic        rst_n, SS_n, MOSI, tx_valid;
  logic [7:0]  tx_data8;
  logic [15:0] tx_data16;
  logic        miso8, rxv8, busy8, fe8, miso16, rxv16, busy16, fe16;
  logic [9:0]  rx8;
  logic [17:0] rx16;
  int tests = 0, fails = 0, rv8 = 0, fec8 = 0, mc8 = 0;

  always #5 clk = ~clk;

  spi_slave_fsm_p #(.DATA_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso8),
    .rx_data(rx8), .rx_valid(rxv8), .tx_data(tx_data8), .tx_valid(tx_valid),
    .busy(busy8), .frame_err(fe8));

  spi_slave_fsm_p #(.DATA_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso16),
    .rx_data(rx16), .rx_valid(rxv16), .tx_data(tx_data16), .tx_valid(tx_valid),
    .busy(busy16), .frame_err(fe16));

  always @(negedge clk) begin
    if (rxv8)  rv8++;
    if (fe8)   fec8++;
    if (miso8) mc8++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic route);
    SS_n = 1'b0;
    tick();
    MOSI = route;
    tick();
  endtask

  task automatic frame(input int n, input logic [31:0] f);
    for (int i = n-1; i >= 0; i--) begin
      MOSI = f[i];
      tick();
    end
  endtask

  task automatic stop();
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    SS_n = 1'b1;
    MOSI = 1'b0;
    tx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int b0, f0, m0;
    logic [7:0]  e8;
    logic [15:0] e16;
    tx_data8 = 8'h00;
    tx_data16 = 16'h0000;
    do_reset();
    chk("rst_miso", miso8, 0);
    chk("rst_rx", rx8, 0);
    chk("rst_rxv", rxv8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_fe", fe8, 0);

    b0 = rv8; m0 = mc8; f0 = fec8;
    start(1'b0);
    chk("wr_busy", busy8, 1);
    frame(9, 32'h052);
    chk("wr_partial", rx8, 0);
    frame(1, 32'h1);
    chk("wr_rxv", rxv8, 1);
    chk("wr_rx", rx8, 10'h0A5);
    tick();
    chk("wr_rxv_off", rxv8, 0);
    stop();
    chk("wr_pulses", rv8 - b0, 1);
    chk("wr_miso", mc8 - m0, 0);
    chk("wr_noerr", fec8 - f0, 0);
    chk("wr_idle", busy8, 0);

    b0 = rv8;
    start(1'b0);
    frame(5, 32'h16);
    SS_n = 1'b1;
    tick();
    chk("ab_fe", fe8, 1);
    chk("ab_idle", busy8, 0);
    tick();
    chk("ab_fe_off", fe8, 0);
    chk("ab_norxv", rv8 - b0, 0);
    chk("ab_rx", rx8, 10'h0A5);

    b0 = rv8;
    start(1'b0);
    frame(9, 32'h1FF);
    MOSI = 1'b1;
    SS_n = 1'b1;
    tick();
    chk("sim_fe", fe8, 1);
    tick();
    chk("sim_norxv", rv8 - b0, 0);
    chk("sim_rx", rx8, 10'h0A5);

    start(1'b1);
    frame(10, 32'h23C);
    stop();
    chk("ra_rx", rx8, 10'h23C);

    tx_valid = 1'b1;
    tx_data8 = 8'hC3;
    e8 = 8'hC3;
    start(1'b1);
    frame(10, 32'h300);
    chk("rd_rx", rx8, 10'h300);
    chk("rd_wait_miso", miso8, 0);
    for (int k = 7; k >= 0; k--) begin
      tick();
      chk($sformatf("rd_bit%0d", k), miso8, e8[k]);
    end
    tick();
    chk("rd_end_miso", miso8, 0);
    tick();
    chk("rd_done_miso", miso8, 0);
    stop();

    start(1'b1);
    frame(10, 32'h3FF);
    tick();
    tick();
    chk("rd3_noshift", miso8, 0);
    chk("rd3_busy", busy8, 1);
    stop();

    tx_valid = 1'b0;
    tx_data8 = 8'hA5;
    start(1'b1);
    frame(10, 32'h300);
    m0 = mc8;
    repeat (4) tick();
    chk("dly_hold", mc8 - m0, 0);
    tx_valid = 1'b1;
    tick();
    chk("dly_msb", miso8, 1);
    tick();
    chk("dly_b6", miso8, 0);
    tick();
    chk("dly_b5", miso8, 1);
    rst_n = 1'b0;
    #1;
    chk("rstm_miso", miso8, 0);
    chk("rstm_busy", busy8, 0);
    chk("rstm_rx", rx8, 0);
    chk("rstm_fe", fe8, 0);
    SS_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    start(1'b1);
    frame(10, 32'h3FF);
    chk("post_rx", rx8, 10'h3FF);
    tick();
    chk("post_readadd", miso8, 0);
    stop();

    do_reset();
    start(1'b0);
    frame(18, 32'h2BEEF);
    chk("w16_rx", rx16, 18'h2BEEF);
    chk("w16_rxv", rxv16, 1);
    stop();
    start(1'b1);
    frame(18, 32'h0);
    stop();
    tx_valid = 1'b1;
    tx_data16 = 16'h8001;
    e16 = 16'h8001;
    start(1'b1);
    frame(18, 32'h30000);
    for (int k = 15; k >= 0; k--) begin
      tick();
      chk($sformatf("r16_bit%0d", k), miso16, e16[k]);
    end
    tick();
    chk("r16_end", miso16, 0);
    stop();
    chk("r16_idle", busy16, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
